// File: rtl/sw_debounce_led_pkg.sv
// Shared constants and types for the two-switch debounce / LED toggle block.
package sw_debounce_led_pkg;

    localparam int unsigned DB_CYCLES_DEF  = 50000;
    localparam int unsigned RPT_DELAY_DEF  = 25000000;
    localparam int unsigned RPT_PERIOD_DEF = 5000000;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned RPT_W = 32;

    // Level a raw active-low switch shows when nobody is pressing it.
    localparam logic RELEASED = 1'b1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [RPT_W-1:0] rpt_t;

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-flop synchronizer, debounce counter, registered press pulse.
// Optional auto-repeat is built only when SW_AUTOREPEAT_EN is defined.
module sw_debounce_ch
    import sw_debounce_led_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF,
    parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
    parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic db,
    output logic press,
    output logic press_evt
);

    logic sync1;
    logic sync2;
    logic db_d;
    logic level;
    logic rise;
    cnt_t cnt;

    // NOTE: every flop here uses a synchronous reset and non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RELEASED;
            sync2 <= RELEASED;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
        end
    end

    assign level = ~sync2;

    // Counter restarts on any sample matching db, so it can never exceed DB_CYCLES-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (level == db) begin
            cnt <= '0;
        end else if (cnt == cnt_t'(DB_CYCLES - 1)) begin
            db  <= level;
            cnt <= '0;
        end else begin
            cnt <= cnt + cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_d  <= 1'b0;
            press <= 1'b0;
        end else begin
            db_d  <= db;
            press <= press_evt;
        end
    end

    assign rise = db & ~db_d;

`ifdef SW_AUTOREPEAT_EN
    rpt_t rpt_cnt;
    logic rpt_hit;

    // rpt_cnt holds (cycles since press - 1); reload assumes RPT_PERIOD <= RPT_DELAY.
    assign rpt_hit = db && db_d && (rpt_cnt == rpt_t'(RPT_DELAY - 1));

    always_ff @(posedge clk) begin
        if (rst || !db) begin
            rpt_cnt <= '0;
        end else if (rise) begin
            rpt_cnt <= '0;
        end else if (rpt_hit) begin
            rpt_cnt <= rpt_t'(RPT_DELAY - RPT_PERIOD);
        end else begin
            rpt_cnt <= rpt_cnt + rpt_t'(1);
        end
    end

    assign press_evt = rise | rpt_hit;
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{RPT_DELAY, RPT_PERIOD};
    assign press_evt      = rise;
`endif

endmodule

// File: rtl/sw_debounce_led.sv
// Two debounced push switches driving toggle LEDs and a both-pressed LED.
// Define SW_AUTOREPEAT_EN to enable auto-repeat press pulses while a switch is held.
module sw_debounce_led
    import sw_debounce_led_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF,
    parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
    parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW1,
    input  logic SW2,
    output logic PRESS1,
    output logic PRESS2,
    output logic LED0,
    output logic LED1,
    output logic LED2
);

    logic db1;
    logic db2;
    logic evt1;
    logic evt2;

    sw_debounce_ch #(
        .DB_CYCLES (DB_CYCLES),
        .RPT_DELAY (RPT_DELAY),
        .RPT_PERIOD(RPT_PERIOD)
    ) u_ch1 (
        .clk      (CLK),
        .rst      (RST),
        .sw       (SW1),
        .db       (db1),
        .press    (PRESS1),
        .press_evt(evt1)
    );

    sw_debounce_ch #(
        .DB_CYCLES (DB_CYCLES),
        .RPT_DELAY (RPT_DELAY),
        .RPT_PERIOD(RPT_PERIOD)
    ) u_ch2 (
        .clk      (CLK),
        .rst      (RST),
        .sw       (SW2),
        .db       (db2),
        .press    (PRESS2),
        .press_evt(evt2)
    );

    // Toggle on the same strobe that loads PRESSn so LED and pulse move together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            LED0 <= 1'b0;
            LED1 <= 1'b0;
            LED2 <= 1'b0;
        end else begin
            LED0 <= LED0 ^ evt1;
            LED1 <= LED1 ^ evt2;
            LED2 <= db1 & db2;
        end
    end

endmodule

// File: tb/tb_sw_debounce_led.sv
// Self-checking bench for sw_debounce_led: per-cycle model comparison plus directed scenarios.
module tb_sw_debounce_led;

    localparam int unsigned DB  = 4;
    localparam int unsigned RD  = 10;
    localparam int unsigned RP  = 3;

    logic clk = 1'b0;
    logic rst;
    logic sw1;
    logic sw2;
    logic press1;
    logic press2;
    logic led0;
    logic led1;
    logic led2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sw_debounce_led #(
        .DB_CYCLES (DB),
        .RPT_DELAY (RD),
        .RPT_PERIOD(RP)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .SW1   (sw1),
        .SW2   (sw2),
        .PRESS1(press1),
        .PRESS2(press2),
        .LED0  (led0),
        .LED1  (led1),
        .LED2  (led2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pins seen 2 edges late, a level is accepted after DB
    // consecutive differing samples, the press is reported the edge after acceptance.
    logic hist1 [2];
    logic hist2 [2];
    logic m_db [2];
    logic m_db_prev [2];
    logic m_press [2];
    logic m_led [2];
    logic m_led2;
    int   m_run [2];
    int   m_age [2];
    bit   model_valid = 1'b0;

    always @(posedge clk) begin
        logic raw [2];
        raw[0] = sw1;
        raw[1] = sw2;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                hist1[c] = 1'b1;  hist2[c] = 1'b1;
                m_db[c] = 1'b0;   m_db_prev[c] = 1'b0;
                m_press[c] = 1'b0; m_led[c] = 1'b0;
                m_run[c] = 0;     m_age[c] = 0;
            end
            m_led2 = 1'b0;
            model_valid = 1'b1;
        end else begin
            m_led2 = m_db[0] & m_db[1];
            for (int c = 0; c < 2; c++) begin
                logic pre;
                logic lvl;
                logic fire;
                pre = m_db[c];
                lvl = !hist2[c];
                hist2[c] = hist1[c];
                hist1[c] = raw[c];
                fire = pre && !m_db_prev[c];
                if (fire) m_age[c] = 0;
                else if (pre) begin
                    m_age[c]++;
`ifdef SW_AUTOREPEAT_EN
                    if (m_age[c] >= int'(RD) && ((m_age[c] - int'(RD)) % int'(RP)) == 0) fire = 1'b1;
`endif
                end
                m_db_prev[c] = pre;
                if (lvl != m_db[c]) begin
                    m_run[c]++;
                    if (m_run[c] == int'(DB)) begin
                        m_db[c] = lvl;
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_press[c] = fire;
                m_led[c]   = m_led[c] ^ fire;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_press1", 32'(press1), 32'(m_press[0]));
            check("model_press2", 32'(press2), 32'(m_press[1]));
            check("model_led0",   32'(led0),   32'(m_led[0]));
            check("model_led1",   32'(led1),   32'(m_led[1]));
            check("model_led2",   32'(led2),   32'(m_led2));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        int at;
        int led0_start;

        // Reset held with both switches pressed
        rst = 1'b1; sw1 = 1'b0; sw2 = 1'b0;
        repeat (3) next_cycle();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            if (k == 5) begin
                check("rst_c5_outs", 32'({press1, press2, led0, led1, led2}), 32'd0);
            end
            if (k == 6) check("rst_c6_press1", 32'(press1), 32'd0);
            if (k == 7) begin
                check("rst_c7_press", 32'({press1, press2}), 32'b11);
                check("rst_c7_leds",  32'({led0, led1, led2}), 32'b111);
            end
            if (k == 8) begin
                check("rst_c8_press1", 32'(press1), 32'd0);
                check("rst_c8_leds",   32'({led0, led1, led2}), 32'b111);
            end
        end

        // Release: no pulse, LEDs 0/1 keep their state
        sw1 = 1'b1; sw2 = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            if (press1 || press2) pulses++;
        end
        check("release_no_pulse", 32'(pulses), 32'd0);
        check("release_leds", 32'({led0, led1, led2}), 32'b110);

        // Bounce on SW1: 3 low, 1 high, then low held
        sw1 = 1'b0; repeat (3) next_cycle();
        sw1 = 1'b1; next_cycle();
        sw1 = 1'b0;
        pulses = 0; at = -1;
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            if (press1) begin pulses++; at = k; end
        end
        check("bounce_pulses", 32'(pulses), 32'd1);
        check("bounce_cycle",  32'(at), 32'd7);
        check("bounce_led0",   32'(led0), 32'd0);

        // Simultaneous press on both channels
        sw1 = 1'b1;
        repeat (12) next_cycle();
        sw1 = 1'b0; sw2 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            if (k == 6) check("both_c6_led2", 32'(led2), 32'd0);
            if (k == 7) begin
                check("both_c7_press", 32'({press1, press2}), 32'b11);
                check("both_c7_leds",  32'({led0, led1}), 32'b10);
                check("both_c7_led2",  32'(led2), 32'd1);
            end
        end

        // Reset mid-count on SW2
        sw1 = 1'b1; sw2 = 1'b1;
        repeat (12) next_cycle();
        sw2 = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            if (press2) pulses++;
        end
        check("midrst_no_early", 32'(pulses), 32'd0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check("midrst_leds", 32'({press2, led0, led1, led2}), 32'd0);
        pulses = 0; at = -1;
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            if (press2) begin pulses++; at = k; end
        end
        check("midrst_pulses", 32'(pulses), 32'd1);
        check("midrst_cycle",  32'(at), 32'd7);
        check("midrst_led1",   32'(led1), 32'd1);

        // Long hold on SW1 (auto-repeat when enabled)
        sw2 = 1'b1;
        repeat (12) next_cycle();
        led0_start = int'(led0);
        sw1 = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 25; k++) begin
            next_cycle();
            if (press1) pulses++;
        end
        sw1 = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            next_cycle();
            if (press1) pulses++;
        end
`ifdef SW_AUTOREPEAT_EN
        check("hold_pulses", 32'(pulses), 32'd6);
        check("hold_led0",   32'(led0), 32'(led0_start));
`else
        check("hold_pulses", 32'(pulses), 32'd1);
        check("hold_led0",   32'(led0), 32'(led0_start ^ 1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
